// File: rtl/pe_arr_pkg.sv
// Shared definitions for the PE array sequencer.
//   ctrl_state_t : sequencer FSM states
//   DATA_W       : operand byte width per lane
//   drain_len()  : cycles from the last buffer read until every PE result is final
package pe_arr_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } ctrl_state_t;

   // Covers buffer latency (1), the output register (1), the skew and
   // propagation across the array (ROWS-1 + COLS-1) and the PE pipeline.
   function automatic int unsigned drain_len(input int unsigned rows,
                                             input int unsigned cols,
                                             input int unsigned pe_lat);
      return rows + cols + pe_lat;
   endfunction

endpackage

// File: rtl/skew_line.sv
// Zero-reset register chain used to delay one array lane.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of every stage
//   d        : lane input
//   q        : lane input delayed by DEPTH cycles
module skew_line
   import pe_arr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         stage_d[i] = '0;
      end
      if (!clr) begin
         stage_d[0] = d;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_arr_ctrl.sv
// Sequencer for a ROWS x COLS systolic PE array.
// On start: one accumulator clear cycle, K buffer reads (addresses 0..K-1),
// diagonally skewed lane data plus a fire wavefront into the array, a drain
// period until all PE results are final, then a one-cycle done pulse.
//   start/k_len/abort         : job control (k_len sampled with start in IDLE)
//   buf_rd_en/buf_rd_addr     : read port shared by weight and activation buffers
//   w_rd_data/a_rd_data       : buffer data, valid one cycle after buf_rd_en
//   arr_w/arr_a/arr_fire      : skewed operands and fire into the array
//   acc_clr/busy/done/err     : status pulses and levels
module pe_arr_ctrl
   import pe_arr_pkg::*;
#(
   parameter int unsigned ROWS   = 8,
   parameter int unsigned COLS   = 8,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned PE_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W:0]        k_len,
   input  logic                   abort,
   output logic                   buf_rd_en,
   output logic [ADDR_W-1:0]      buf_rd_addr,
   input  logic [DATA_W*COLS-1:0] w_rd_data,
   input  logic [DATA_W*ROWS-1:0] a_rd_data,
   output logic [DATA_W*COLS-1:0] arr_w,
   output logic [DATA_W*ROWS-1:0] arr_a,
   output logic                   arr_fire,
   output logic                   acc_clr,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned DL    = drain_len(ROWS, COLS, PE_LAT);
   localparam int unsigned CNT_W = (DL > 1) ? $clog2(DL) : 1;

   ctrl_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] k_last_q, k_last_d;
   logic [CNT_W-1:0]  drain_q, drain_d;
   logic              err_q, err_d;
   logic              rd_vld_q, rd_vld_d;
   logic              active;
   logic              skew_clr;

   logic [DATA_W*COLS-1:0] w_in;
   logic [DATA_W*ROWS-1:0] a_in;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      k_last_d = k_last_q;
      drain_d  = drain_q;
      err_d    = 1'b0;
      active   = (state_q == CLEAR) || (state_q == FEED) || (state_q == DRAIN);

      case (state_q)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  // K-1 fits in ADDR_W bits, so K = 2**ADDR_W ends at all-ones without wrap.
                  k_last_d = ADDR_W'(k_len - (ADDR_W+1)'(1));
                  state_d  = CLEAR;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         CLEAR: begin
            addr_d  = '0;
            state_d = abort ? IDLE : FEED;
         end
         FEED: begin
            if (abort) begin
               addr_d  = '0;
               state_d = IDLE;
            end else if (addr_q == k_last_q) begin
               addr_d  = '0;
               drain_d = '0;
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (abort) begin
               drain_d = '0;
               state_d = IDLE;
            end else if (drain_q == CNT_W'(DL - 1)) begin
               drain_d = '0;
               state_d = DONE;
            end else begin
               drain_d = drain_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An abort flushes everything in flight on the same edge the FSM leaves.
      skew_clr = active && abort;
      rd_vld_d = (state_q == FEED) && !skew_clr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         k_last_q <= '0;
         drain_q  <= '0;
         err_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         k_last_q <= k_last_d;
         drain_q  <= drain_d;
         err_q    <= err_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign acc_clr     = (state_q == CLEAR);
   assign buf_rd_en   = (state_q == FEED);
   assign buf_rd_addr = addr_q;
   assign done        = (state_q == DONE);
   assign err         = err_q;

   assign w_in = rd_vld_q ? w_rd_data : '0;
   assign a_in = rd_vld_q ? a_rd_data : '0;

   for (genvar c = 0; c < COLS; c++) begin : g_w_lane
      skew_line #(
         .WIDTH(DATA_W),
         .DEPTH(c + 1)
      ) u_skew (
         .clk(clk),
         .rst(rst),
         .clr(skew_clr),
         .d  (w_in[DATA_W*c +: DATA_W]),
         .q  (arr_w[DATA_W*c +: DATA_W])
      );
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_a_lane
      skew_line #(
         .WIDTH(DATA_W),
         .DEPTH(r + 1)
      ) u_skew (
         .clk(clk),
         .rst(rst),
         .clr(skew_clr),
         .d  (a_in[DATA_W*r +: DATA_W]),
         .q  (arr_a[DATA_W*r +: DATA_W])
      );
   end

   skew_line #(
      .WIDTH(1),
      .DEPTH(1)
   ) u_fire (
      .clk(clk),
      .rst(rst),
      .clr(skew_clr),
      .d  (rd_vld_q),
      .q  (arr_fire)
   );

endmodule
